// File: rtl/race_reaction_monitor.sv
// -----------------------------------------------------------------------------
// race_reaction_monitor
// Receiving end of the race light interface. Watches the Red/Yellow/Green lamp
// lines from the light controller and the racer's button, measures reaction
// time in millisecond ticks from Green onset to the press, and flags false
// starts, timeouts and illegal lamp codes/sequences.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   Red        in   red lamp level (Clk-synchronous)
//   Yellow     in   yellow lamp level (Clk-synchronous)
//   Green      in   green lamp level (Clk-synchronous)
//   Btn        in   racer button, asynchronous, active-high
//   ReactTime  out  latched reaction time in ms (CNT_W bits)
//   Valid      out  one-cycle pulse when ReactTime holds a new measurement
//   FalseStart out  press seen while Yellow (armed)
//   Timeout    out  no press within TIMEOUT_MS of Green, or Green ended early
//   Fault      out  sticky, illegal lamp code or order; cleared only by Reset
//   Busy       out  high while ARMED or TIMING
// -----------------------------------------------------------------------------
module race_reaction_monitor #(
    parameter int TICK_DIV   = 1000,
    parameter int CNT_W      = 12,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Red,
    input  logic             Yellow,
    input  logic             Green,
    input  logic             Btn,
    output logic [CNT_W-1:0] ReactTime,
    output logic             Valid,
    output logic             FalseStart,
    output logic             Timeout,
    output logic             Fault,
    output logic             Busy
);

    localparam int PRE_W = 16;

    localparam logic [2:0] C_DARK = 3'b000;
    localparam logic [2:0] C_G    = 3'b001;
    localparam logic [2:0] C_Y    = 3'b010;
    localparam logic [2:0] C_R    = 3'b100;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_MS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_TIMING = 3'd2,
        S_DONE   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t           r_state;
    logic [2:0]       r_prev_code;
    logic             r_btn_s1;
    logic             r_btn_s2;
    logic             r_btn_s3;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]       w_code;
    logic             w_press;
    logic             w_wrap;
    logic             w_illegal;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_code  = {Red, Yellow, Green};
    assign w_press = r_btn_s2 & ~r_btn_s3;
    assign w_wrap  = (r_pre == PRE_LAST);

    // Classify the current lamp code: only one-hot or all-dark is legal.
    always_comb begin
        w_illegal = 1'b1;
        case (w_code)
            C_DARK, C_G, C_Y, C_R: w_illegal = 1'b0;
            default:               w_illegal = 1'b1;
        endcase
    end

    // Counter value after this edge's tick; ReactTime captures this so a
    // press on the tick edge reports the value the counter reaches.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wrap && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Button synchronizer, lamp history and the monitor state machine.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_prev_code <= 3'b000;
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_s3    <= 1'b0;
            r_pre       <= '0;
            r_cnt       <= '0;
            ReactTime   <= '0;
            Valid       <= 1'b0;
            FalseStart  <= 1'b0;
            Timeout     <= 1'b0;
            Fault       <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            r_btn_s1    <= Btn;
            r_btn_s2    <= r_btn_s1;
            r_btn_s3    <= r_btn_s2;
            r_prev_code <= w_code;
            Valid       <= 1'b0;

            if (w_illegal) begin
                // An illegal code overrides every other event.
                r_state <= S_FAULT;
                Fault   <= 1'b1;
                Busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if ((w_code == C_Y) && (r_prev_code == C_R)) begin
                            r_state    <= S_ARMED;
                            FalseStart <= 1'b0;
                            Timeout    <= 1'b0;
                            r_cnt      <= '0;
                            r_pre      <= '0;
                            Busy       <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_ARMED: begin
                        // Press checked first: a press coinciding with the
                        // switch to Green is still a false start.
                        if (w_press) begin
                            r_state    <= S_DONE;
                            FalseStart <= 1'b1;
                            Busy       <= 1'b0;
                        end else if (w_code == C_G) begin
                            r_state <= S_TIMING;
                            r_pre   <= '0;
                            r_cnt   <= '0;
                        end else if (w_code == C_Y) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_state <= S_FAULT;
                            Fault   <= 1'b1;
                            Busy    <= 1'b0;
                        end
                    end
                    S_TIMING: begin
                        if ((w_code == C_Y) || (w_code == C_DARK)) begin
                            r_state <= S_FAULT;
                            Fault   <= 1'b1;
                            Busy    <= 1'b0;
                        end else if (w_press) begin
                            r_state   <= S_DONE;
                            ReactTime <= w_cnt_next;
                            Valid     <= 1'b1;
                            Busy      <= 1'b0;
                        end else if (w_code == C_R) begin
                            // Green withdrawn before the racer reacted.
                            r_state <= S_DONE;
                            Timeout <= 1'b1;
                            Busy    <= 1'b0;
                        end else if (w_cnt_next == TO_VAL) begin
                            r_state   <= S_DONE;
                            Timeout   <= 1'b1;
                            ReactTime <= TO_VAL;
                            Busy      <= 1'b0;
                        end else begin
                            r_pre <= w_wrap ? '0 : (r_pre + PRE_W'(1));
                            r_cnt <= w_cnt_next;
                        end
                    end
                    S_DONE: begin
                        if (w_code == C_R) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                    S_FAULT: begin
                        r_state <= S_FAULT;
                        Fault   <= 1'b1;
                        Busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_FAULT;
                        Fault   <= 1'b1;
                        Busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_race_reaction_monitor.sv
// -----------------------------------------------------------------------------
// Directed testbench for race_reaction_monitor with TICK_DIV=4, TIMEOUT_MS=20.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_race_reaction_monitor;

    localparam int CNT_W = 12;

    localparam logic [2:0] L_DARK = 3'b000;
    localparam logic [2:0] L_R    = 3'b100;
    localparam logic [2:0] L_Y    = 3'b010;
    localparam logic [2:0] L_G    = 3'b001;
    localparam logic [2:0] L_RY   = 3'b110;

    logic             Clk;
    logic             Reset;
    logic             Red;
    logic             Yellow;
    logic             Green;
    logic             Btn;
    logic [CNT_W-1:0] ReactTime;
    logic             Valid;
    logic             FalseStart;
    logic             Timeout;
    logic             Fault;
    logic             Busy;

    int n_checks;
    int n_fail;
    int n_valid;

    race_reaction_monitor #(
        .TICK_DIV  (4),
        .CNT_W     (CNT_W),
        .TIMEOUT_MS(20)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Red       (Red),
        .Yellow    (Yellow),
        .Green     (Green),
        .Btn       (Btn),
        .ReactTime (ReactTime),
        .Valid     (Valid),
        .FalseStart(FalseStart),
        .Timeout   (Timeout),
        .Fault     (Fault),
        .Busy      (Busy)
    );

    // Free-running clock, period 10.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count Valid pulses so stretches with no expected Valid can be checked.
    always @(negedge Clk) begin
        if (Valid === 1'b1) n_valid <= n_valid + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_lamps(input logic [2:0] c);
        {Red, Yellow, Green} = c;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_react"}, 32'(ReactTime), 32'd0);
        check_value({tag, "_valid"}, 32'(Valid), 32'd0);
        check_value({tag, "_fs"},    32'(FalseStart), 32'd0);
        check_value({tag, "_to"},    32'(Timeout), 32'd0);
        check_value({tag, "_fault"}, 32'(Fault), 32'd0);
        check_value({tag, "_busy"},  32'(Busy), 32'd0);
    endtask

    // Red then Yellow, leaving the monitor ARMED.
    task automatic arm();
        set_lamps(L_R);
        tick(3);
        set_lamps(L_Y);
        tick(3);
    endtask

    int vbase;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_valid  = 0;
        Reset    = 1'b1;
        Btn      = 1'b0;
        set_lamps(L_DARK);
        tick(2);
        Reset = 1'b0;
        check_reset_outputs("reset");

        // Normal reaction: R 10, Y 10, G, Btn 30 cycles after G.
        set_lamps(L_R);
        tick(10);
        set_lamps(L_Y);
        tick(10);
        check_value("armed_busy", 32'(Busy), 32'd1);
        set_lamps(L_G);
        tick(30);
        Btn = 1'b1;
        tick(2);
        check_value("react_valid_early", 32'(Valid), 32'd0);
        tick(1);
        check_value("react_valid", 32'(Valid), 32'd1);
        check_value("react_time", 32'(ReactTime), 32'd8);
        check_value("react_fs", 32'(FalseStart), 32'd0);
        check_value("react_to", 32'(Timeout), 32'd0);
        tick(1);
        check_value("react_valid_pulse", 32'(Valid), 32'd0);
        check_value("react_busy_done", 32'(Busy), 32'd0);
        Btn = 1'b0;

        // False start during Yellow.
        set_lamps(L_R);
        tick(2);
        set_lamps(L_Y);
        tick(3);
        vbase = n_valid;
        Btn = 1'b1;
        tick(1);
        Btn = 1'b0;
        tick(1);
        check_value("fs_early", 32'(FalseStart), 32'd0);
        tick(1);
        check_value("fs_set", 32'(FalseStart), 32'd1);
        check_value("fs_busy", 32'(Busy), 32'd0);
        set_lamps(L_G);
        tick(5);
        set_lamps(L_R);
        tick(2);
        check_value("fs_held", 32'(FalseStart), 32'd1);
        check_value("fs_no_valid", 32'(n_valid - vbase), 32'd0);
        check_value("fs_react_kept", 32'(ReactTime), 32'd8);
        set_lamps(L_Y);
        tick(1);
        check_value("fs_cleared", 32'(FalseStart), 32'd0);
        check_value("fs_rearmed", 32'(Busy), 32'd1);

        // Timeout: Green held with no press; tick edge 80 reaches 20.
        vbase = n_valid;
        set_lamps(L_G);
        tick(80);
        check_value("to_not_yet", 32'(Timeout), 32'd0);
        check_value("to_busy", 32'(Busy), 32'd1);
        tick(1);
        check_value("to_set", 32'(Timeout), 32'd1);
        check_value("to_react", 32'(ReactTime), 32'd20);
        check_value("to_busy_off", 32'(Busy), 32'd0);
        tick(20);
        check_value("to_held", 32'(Timeout), 32'd1);
        check_value("to_no_valid", 32'(n_valid - vbase), 32'd0);

        // Press on the same edge the counter reaches 20.
        set_lamps(L_R);
        tick(2);
        set_lamps(L_Y);
        tick(1);
        check_value("race_to_cleared", 32'(Timeout), 32'd0);
        set_lamps(L_G);
        tick(78);
        Btn = 1'b1;
        tick(2);
        check_value("race_valid_early", 32'(Valid), 32'd0);
        tick(1);
        check_value("race_valid", 32'(Valid), 32'd1);
        check_value("race_react", 32'(ReactTime), 32'd20);
        check_value("race_to", 32'(Timeout), 32'd0);
        Btn = 1'b0;

        // Illegal code during TIMING, then frozen until reset.
        arm();
        set_lamps(L_G);
        tick(5);
        set_lamps(L_RY);
        tick(1);
        check_value("ill_fault", 32'(Fault), 32'd1);
        check_value("ill_busy", 32'(Busy), 32'd0);
        vbase = n_valid;
        set_lamps(L_R);
        tick(3);
        set_lamps(L_Y);
        tick(3);
        set_lamps(L_G);
        Btn = 1'b1;
        tick(6);
        Btn = 1'b0;
        check_value("ill_fault_sticky", 32'(Fault), 32'd1);
        check_value("ill_busy_frozen", 32'(Busy), 32'd0);
        check_value("ill_react_frozen", 32'(ReactTime), 32'd20);
        check_value("ill_no_valid", 32'(n_valid - vbase), 32'd0);
        do_reset();
        check_reset_outputs("ill_reset");

        // Reset asserted while TIMING.
        arm();
        set_lamps(L_G);
        tick(10);
        check_value("rst_timing_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        tick(1);
        check_reset_outputs("rst_timing");
        Reset = 1'b0;
        tick(5);
        check_value("rst_idle_ignores_g", 32'(Busy), 32'd0);

        // Red straight to Green in IDLE is ignored.
        set_lamps(L_R);
        tick(2);
        set_lamps(L_G);
        tick(3);
        check_value("rg_idle_busy", 32'(Busy), 32'd0);
        check_value("rg_idle_fault", 32'(Fault), 32'd0);

        // Btn glitch shorter than a clock period while ARMED.
        arm();
        Btn = 1'b1;
        #3;
        Btn = 1'b0;
        tick(5);
        check_value("glitch_fs", 32'(FalseStart), 32'd0);
        check_value("glitch_busy", 32'(Busy), 32'd1);

        // Yellow back to Red while ARMED is a sequence fault.
        set_lamps(L_R);
        tick(1);
        check_value("yr_fault", 32'(Fault), 32'd1);
        check_value("yr_busy", 32'(Busy), 32'd0);
        do_reset();
        check_value("yr_reset_fault", 32'(Fault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/race_reaction_monitor.md
Name: race_reaction_monitor

Overview:
- Receiving end of the race light interface: watches the Red/Yellow/Green lamp lines driven by the race light controller, plus the racer's Btn input.
- Measures racer reaction time in millisecond ticks from Green onset to button press.
- Flags false starts, timeouts and illegal lamp sequences.
- Sits beside the light controller in the race-start subsystem; feeds a display/scoring block.

Parameters:
- TICK_DIV, 1000: Clk cycles per 1 ms tick (range 2..65535).
- CNT_W, 12: width of the reaction-time counter.
- TIMEOUT_MS, 2000: ms in Green without a press before Timeout. Must be < 2^CNT_W.

Ports:
- Clk  input  1  system clock, rising-edge active
- Reset  input  1  synchronous, active-high reset
- Red  input  1  red lamp from light controller (level, Clk-synchronous)
- Yellow  input  1  yellow lamp (level, Clk-synchronous)
- Green  input  1  green lamp (level, Clk-synchronous)
- Btn  input  1  racer button, asynchronous, active-high
- ReactTime  output  CNT_W  latched reaction time in ms
- Valid  output  1  one-cycle pulse when ReactTime updates
- FalseStart  output  1  level, press during Yellow
- Timeout  output  1  level, no press within TIMEOUT_MS of Green
- Fault  output  1  sticky, illegal lamp code or order
- Busy  output  1  high in ARMED or TIMING

Behaviour:
- One clock; reset is synchronous and active-high: Clk rising edge, Reset sampled only on that edge.
- Reset values: state=IDLE, ReactTime=0, Valid=0, FalseStart=0, Timeout=0, Fault=0, Busy=0. Prescaler and counter=0, sync flops=0.
- Reset asserted mid-run (any state) aborts on that edge.
- Btn path: 2-flop synchronizer, then rising-edge detect (press = sync2 & ~sync3). Press latency is 3 Clk edges from the Btn change.
- Lamp decode (registered previous code kept):
  - 100=R, 010=Y, 001=G, 000=DARK.
  - Any other code is ILLEGAL: go to FAULT next edge, from any state.
- States:
  - IDLE: wait for code Y with previous code R, then go to ARMED. On that entry, clear FalseStart, Timeout and counter. Any other code is ignored.
  - ARMED:
    - press -> FalseStart=1, go to DONE.
    - code G -> go to TIMING; prescaler=0, counter=0.
    - code R or DARK -> FAULT (sequence violation).
    - Y holds.
  - TIMING:
    - Prescaler counts 0..TICK_DIV-1. On wrap, counter += 1, saturating at 2^CNT_W-1.
    - press -> ReactTime=counter, Valid=1 for one cycle, go to DONE.
    - counter == TIMEOUT_MS with no press -> Timeout=1, ReactTime=TIMEOUT_MS, no Valid, go to DONE.
    - code Y or DARK -> FAULT. Code R (green ended early) -> Timeout=1, go to DONE.
  - DONE: hold ReactTime and flags. Code R -> IDLE. Presses are ignored.
  - FAULT: Fault=1, Busy=0, all other outputs frozen. Exits only on Reset.
- Simultaneous events:
  - Press on the same edge as the Y->G code change counts as a false start (ARMED rule wins).
  - Press on the same edge that counter reaches TIMEOUT_MS: press wins. Valid=1, ReactTime=TIMEOUT_MS, Timeout=0.
  - ILLEGAL code beats every other event.
- Red->Green direct (Yellow skipped) while in IDLE: ignored, no timing. While in ARMED: FAULT.
- ReactTime changes only on Valid, on timeout latch, or on Reset.

Test Plan:
- TICK_DIV=4, TIMEOUT_MS=20. Sequence R(10 cyc)->Y(10)->G; Btn rises 30 cycles after G -> Valid pulse 3 cycles after Btn; ReactTime=8 (33 cyc/4); FalseStart=0, Timeout=0.
- Btn pulse during Yellow -> FalseStart=1 within 3 cycles; no Valid. Green then R -> IDLE with FalseStart held. Next Y clears FalseStart.
- G held 100 cycles, no press -> Timeout=1 at counter 20; ReactTime=20; Valid never asserted.
- Drive code 110 during TIMING -> Fault=1 next edge. Then R/Y/G and presses -> no change. Reset for 1 cycle -> all outputs 0, state IDLE.
- Press arrives exactly on the edge counter hits 20 -> Valid=1, ReactTime=20, Timeout=0. Separately, Reset asserted in TIMING -> outputs return to reset values on that edge.
- Y->R (no Green) while ARMED -> Fault=1. Separately, Btn glitch shorter than 1 Clk period -> no press registered.
